// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline request port and a single-ported 64-bit data memory.
// One transaction at a time: IDLE accepts, ACCESS strobes the memory, RESP holds the result until taken.
module mem_access_unit #(
    parameter int MEM_WORDS   = 256,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        stall,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_readdata
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int HI = 3 + AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic            wr_p0;
    logic [AW-1:0]   idx_p0;
    logic [63:0]     wdata_p0;
    logic [63:0]     rdata_p1;
    logic            err_p1;

    function automatic logic is_misaligned(input logic [63:0] a);
        return (ALIGN_CHECK != 0) && (a[2:0] != 3'b000);
    endfunction

    function automatic logic is_out_of_range(input logic [63:0] a);
        return (a >> HI) != 64'd0;
    endfunction

    logic req_bad;
    assign req_bad = is_misaligned(req_addr) || is_out_of_range(req_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_p0    <= 1'b0;
            idx_p0   <= '0;
            wdata_p0 <= '0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else begin
            case (state)
                // request capture: rejected requests skip the memory entirely
                IDLE: begin
                    if (req_valid) begin
                        wr_p0    <= req_write;
                        idx_p0   <= req_addr[HI-1:3];
                        wdata_p0 <= req_wdata;
                        rdata_p1 <= '0;
                        err_p1   <= req_bad;
                        state    <= req_bad ? RESP : ACCESS;
                    end
                end
                // memory stage: read data was registered by the memory on the preceding negedge
                ACCESS: begin
                    rdata_p1 <= wr_p0 ? 64'd0 : mem_readdata;
                    state    <= RESP;
                end
                // response stage: held until the consumer takes it
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign stall          = (state != IDLE);
    assign resp_valid     = (state == RESP);
    assign resp_rdata     = rdata_p1;
    assign resp_error     = err_p1;
    assign mem_address    = {{(64-AW){1'b0}}, idx_p0};
    assign mem_write_data = wdata_p0;

    // Strobes are gated by reset directly so a store caught mid-ACCESS never commits.
    assign mem_write = (state == ACCESS) && wr_p0  && !reset;
    assign mem_read  = (state == ACCESS) && !wr_p0 && !reset;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 256, giving the number of 64-bit words in the attached data memory (power of two, 2..256).
REQ-002 The module SHALL have parameter ALIGN_CHECK, default 1; when 1, misaligned byte addresses are rejected.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have port clk, input, 1, system clock; all state changes on posedge.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port req_valid, input, 1, pipeline presents a load/store request.
REQ-007 The module SHALL have port req_ready, output, 1, unit can accept a request this cycle.
REQ-008 The module SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-009 The module SHALL have port req_addr, input, 64, byte address.
REQ-010 The module SHALL have port req_wdata, input, 64, store data.
REQ-011 The module SHALL have port resp_valid, output, 1, response available.
REQ-012 The module SHALL have port resp_ready, input, 1, consumer takes the response.
REQ-013 The module SHALL have port resp_rdata, output, 64, load data (0 for stores and errors).
REQ-014 The module SHALL have port resp_error, output, 1, request rejected (misaligned or out of range).
REQ-015 The module SHALL have port stall, output, 1, high whenever state is not IDLE.
REQ-016 The module SHALL have port mem_address, output, 64, word index to the data memory.
REQ-017 The module SHALL have port mem_write_data, output, 64, store data to the data memory.
REQ-018 The module SHALL have port mem_write, output, 1, memory write strobe (memory commits on posedge).
REQ-019 The module SHALL have port mem_read, output, 1, memory read strobe (memory registers data on negedge).
REQ-020 The module SHALL have port mem_readdata, input, 64, memory read data.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready at posedge.
REQ-023 On accept, the unit SHALL register req_write, req_addr, req_wdata.
REQ-024 Word index SHALL be addr[3+log2(MEM_WORDS)-1:3], zero-extended to 64 bits on mem_address.
REQ-025 A request SHALL be misaligned when ALIGN_CHECK=1 and addr[2:0] != 0.
REQ-026 A request SHALL be out of range when any addr bit at or above 3+log2(MEM_WORDS) is 1.
REQ-027 On accept of a valid request, the next state SHALL be ACCESS; for an erroneous request, it SHALL be RESP with resp_error=1 and resp_rdata=0.
REQ-028 In ACCESS, mem_read or mem_write SHALL be 1 for exactly one cycle, per the registered req_write; the other strobe SHALL be 0.
REQ-029 An erroneous request SHALL never assert mem_read or mem_write.
REQ-030 At the posedge ending ACCESS, a load SHALL capture mem_readdata into resp_rdata; a store SHALL set resp_rdata=0. The next state SHALL be RESP.
REQ-031 In RESP, resp_valid SHALL be 1; resp_rdata and resp_error SHALL be held stable until resp_valid && resp_ready, then the state SHALL return to IDLE.
REQ-032 Latency SHALL be accept to resp_valid = 2 cycles for valid requests and 1 cycle for erroneous ones.
REQ-033 Throughput SHALL be at most one request per 3 cycles; no overlapping transactions.
REQ-034 Outside ACCESS, mem_address and mem_write_data SHALL hold the registered request values; the strobes SHALL be 0.
REQ-035 req_valid changes outside IDLE SHALL be ignored.

Reset
REQ-036 With reset high at posedge: state=IDLE, resp_valid=0, resp_error=0, resp_rdata=0, registered addr/wdata=0.
REQ-037 While reset is high, mem_read and mem_write SHALL be forced 0 combinationally, so a store in ACCESS during reset does not commit.
REQ-038 After reset, req_ready SHALL be 1 and stall SHALL be 0.

Verification
REQ-039 Load case: memory words 0..7 = 1..8; load addr 0x10 -> mem_read high 1 cycle with mem_address=2; resp_valid 2 cycles after accept; resp_rdata=3; resp_error=0.
REQ-040 Store then load: store 0x18 data 0xDEADBEEF -> word 3 = 0xDEADBEEF; a subsequent load of 0x18 -> resp_rdata=0xDEADBEEF.
REQ-041 Misaligned case: load 0x0C -> resp_error=1 one cycle after accept; resp_rdata=0; strobes never asserted.
REQ-042 Out-of-range case: store 0x800 (MEM_WORDS=256) -> resp_error=1; no memory word changed.
REQ-043 Backpressure case: resp_ready=0 for 3 cycles in RESP -> resp_valid, resp_rdata and stall held; req_ready=0; release -> IDLE the next cycle.
REQ-044 Reset in ACCESS: reset high during ACCESS of a store to 0x20 data 9 -> word 4 stays 5; all outputs at reset values the next cycle.
